// File: rtl/inv_key_schedule_pkg.sv
// Shared AES-128 constants for the decryption-side key schedule.
//   Nk/Nr/Nb      : key words, round count, state words
//   Rcon          : forward round-constant table (rounds 1..10)
//   RconStart     : rcon used to step from round 10 back to round 9
//   RconWrap/Next : the one non-shift step of the backward rcon walk
package inv_key_schedule_pkg;

    localparam int unsigned Nk = 4;
    localparam int unsigned Nr = 10;
    localparam int unsigned Nb = 4;

    localparam logic [3:0] LastRound = 4'(Nr);

    localparam logic [7:0] Rcon [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] RconStart    = 8'h36;
    localparam logic [7:0] RconWrap     = 8'h1b;
    localparam logic [7:0] RconWrapNext = 8'h80;

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

endpackage

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the key source/consumer and inv_key_schedule.
//   slave  : the key generator (takes start/last_key/key_ready, drives the rest)
//   master : the environment side
interface inv_key_schedule_if;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    modport slave (
        input  start, last_key, key_ready,
        output round_key, round_idx, key_valid, busy, done
    );

    modport master (
        output start, last_key, key_ready,
        input  round_key, round_idx, key_valid, busy, done
    );
endinterface

// File: rtl/inv_key_schedule_sbytes.sv
// AES SubBytes over NWords 32-bit words, purely combinational.
//   data_in  : NWords*32 bits of input bytes
//   data_out : S-box of each byte, same positions
// The S-box is computed as GF(2^8) inverse (x^254) followed by the affine map,
// which avoids a 256-entry table per byte.
module inv_key_schedule_sbytes #(
    parameter int unsigned NWords = 1
) (
    input  logic [32*NWords-1:0] data_in,
    output logic [32*NWords-1:0] data_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4 * NWords; g++) begin : g_byte
        assign data_out[8*g +: 8] = sbox(data_in[8*g +: 8]);
    end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: loads the round-10 key and walks the schedule
// backwards, presenting round keys 10..0 one per accepted handshake beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/last_key : begin a sequence from the round-10 key (IDLE only)
//   bus.round_key/round_idx/key_valid, bus.key_ready : key stream handshake
//   bus.busy : sequence in progress; bus.done : pulse after round 0 accepted
module inv_key_schedule
    import inv_key_schedule_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    inv_key_schedule_if.slave bus
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3, sub_p3;
    logic [7:0]   rcon_next;

    assign {w0, w1, w2, w3} = key_q;

    // Undo the forward recurrence w[i] = w[i-1] ^ w[i-4].
    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    inv_key_schedule_sbytes #(
        .NWords (1)
    ) u_sub_word (
        .data_in  (rot_p3),
        .data_out (sub_p3)
    );

    assign p0        = w0 ^ sub_p3 ^ {rcon_q, 24'h0};
    // Walking rcon backwards is a right shift except across the 0x80 -> 0x1b reduction.
    assign rcon_next = (rcon_q == RconWrap) ? RconWrapNext : (rcon_q >> 1);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    key_d   = bus.last_key;
                    idx_d   = LastRound;
                    rcon_d  = RconStart;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.key_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d  = {p0, p1, p2, p3};
                        idx_d  = idx_q - 4'd1;
                        rcon_d = rcon_next;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RconStart;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.key_valid = (state_q == StEmit);
    assign bus.busy      = (state_q == StEmit);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed self-checking bench for inv_key_schedule using FIPS-197 A.1 and
// all-zero-key round keys.
module tb_inv_key_schedule;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] fips [0:10];
    logic [127:0] zk10, zk2, zk1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.last_key  = '0;
        bus.key_ready = 1'b0;
        step();
        checks++;
        if ({bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done} !== 135'd0) begin
            errors++;
            $display("FAIL reset_hold: key=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.key_valid, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b done=%b, want 000",
                     bus.key_valid, bus.busy, bus.done);
        end
    endtask

    // Full FIPS sequence at key_ready=1; done must appear on the 12th edge
    // counting the edge that sampled start.
    task automatic test_fips_sequence();
        bus.last_key  = fips[10];
        bus.key_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.last_key = {4{$urandom()}};
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (bus.key_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.round_idx !== 4'(r) || bus.round_key !== fips[r]) begin
                errors++;
                $display("FAIL fips_round%0d: valid=%b busy=%b done=%b idx=%0d key=%h, want 1 1 0 %0d %h",
                         r, bus.key_valid, bus.busy, bus.done, bus.round_idx, bus.round_key,
                         r, fips[r]);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.key_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.round_key !== fips[0]) begin
            errors++;
            $display("FAIL fips_done: done=%b valid=%b busy=%b key=%h, want 1 0 0 %h",
                     bus.done, bus.key_valid, bus.busy, bus.round_key, fips[0]);
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        int exp_r;
        int cycles;
        logic rdy;
        bus.last_key  = fips[10];
        bus.key_ready = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        exp_r  = 10;
        cycles = 0;
        while (exp_r >= 0 && cycles < 400) begin
            checks++;
            if (bus.key_valid !== 1'b1 || bus.done !== 1'b0 ||
                bus.round_idx !== 4'(exp_r) || bus.round_key !== fips[exp_r]) begin
                errors++;
                $display("FAIL bp_round%0d: valid=%b done=%b idx=%0d key=%h, want 1 0 %0d %h",
                         exp_r, bus.key_valid, bus.done, bus.round_idx, bus.round_key,
                         exp_r, fips[exp_r]);
            end
            rdy = 1'($urandom_range(0, 1));
            bus.key_ready = rdy;
            step();
            cycles++;
            if (rdy) exp_r--;
        end
        checks++;
        if (cycles >= 400 || bus.done !== 1'b1 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: cycles=%0d done=%b valid=%b, want <400 1 0",
                     cycles, bus.done, bus.key_valid);
        end
        bus.key_ready = 1'b1;
        step();
    endtask

    task automatic test_start_ignored();
        bus.last_key  = fips[10];
        bus.key_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (bus.key_valid !== 1'b1 || bus.round_idx !== 4'(r) ||
                bus.round_key !== fips[r]) begin
                errors++;
                $display("FAIL ign_round%0d: valid=%b idx=%0d key=%h, want 1 %0d %h",
                         r, bus.key_valid, bus.round_idx, bus.round_key, r, fips[r]);
            end
            bus.start    = (r == 7 || r == 3 || r == 0);
            bus.last_key = zk10;
            step();
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.key_valid !== 1'b0 || bus.round_key !== fips[0]) begin
            errors++;
            $display("FAIL ign_done: done=%b valid=%b key=%h, want 1 0 %h",
                     bus.done, bus.key_valid, bus.round_key, fips[0]);
        end
        step();
    endtask

    task automatic test_reset_mid_sequence();
        bus.last_key  = fips[10];
        bus.key_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 10; r > 5; r--) step();
        checks++;
        if (bus.round_idx !== 4'd5 || bus.round_key !== fips[5]) begin
            errors++;
            $display("FAIL rst_pre: idx=%0d key=%h, want 5 %h",
                     bus.round_idx, bus.round_key, fips[5]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done} !== 135'd0) begin
            errors++;
            $display("FAIL rst_async: key=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.key_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done: done=%b valid=%b, want 0 0", bus.done, bus.key_valid);
            end
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (bus.round_idx !== 4'(r) || bus.round_key !== fips[r]) begin
                errors++;
                $display("FAIL rst_fresh_round%0d: idx=%0d key=%h, want %0d %h",
                         r, bus.round_idx, bus.round_key, r, fips[r]);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_done: done=%b, want 1", bus.done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.last_key  = fips[10];
        bus.key_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 10; r >= 0; r--) step();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b, want 1", bus.done);
        end
        bus.start    = 1'b1;
        bus.last_key = zk10;
        step();
        bus.start    = 1'b0;
        bus.last_key = fips[10];
        for (int r = 10; r >= 0; r--) begin
            logic [127:0] want;
            logic         known;
            known = 1'b1;
            want  = '0;
            case (r)
                10:      want = zk10;
                2:       want = zk2;
                1:       want = zk1;
                0:       want = '0;
                default: known = 1'b0;
            endcase
            checks++;
            if (bus.key_valid !== 1'b1 || bus.round_idx !== 4'(r) ||
                (known && bus.round_key !== want)) begin
                errors++;
                $display("FAIL b2b_round%0d: valid=%b idx=%0d key=%h, want 1 %0d %h",
                         r, bus.key_valid, bus.round_idx, bus.round_key, r, want);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.round_key !== 128'd0) begin
            errors++;
            $display("FAIL b2b_done2: done=%b key=%h, want 1 0", bus.done, bus.round_key);
        end
        step();
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zk10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        zk2      = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zk1      = 128'h62636363626363636263636362636363;

        test_reset();
        test_fips_sequence();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_sequence();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

AES-128 decryption-side key generator: accepts the last round key (round 10) and runs the key schedule backwards, emitting round keys 10 down to 0 one per handshake beat. It sits between the key source and the inverse cipher round datapath and supplies keys in the order decryption consumes them. It is the counterpart of the forward, fully unrolled key expansion: sequential, one 128-bit state register, one SubWord instance.

## Interface
- Nk, 4, key length in words (fixed at 4; other values unsupported)
- Nr, 10, round count (fixed at 10)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock, async active-low reset (decided)
- start  in  1  load last_key and begin a sequence; honoured only in IDLE
- last_key  in  128  round-10 key; word 0 = bits [127:96]
- round_key  out  128  current round key, same word order
- round_idx  out  4  round number of round_key (10..0)
- key_valid  out  1  round_key/round_idx valid
- key_ready  in  1  consumer accepts the beat when key_valid & key_ready
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after round 0 is accepted

## Operation
- States: IDLE, EMIT. Reset -> IDLE; round_key=0, round_idx=0, key_valid=0, busy=0, done=0, rcon register=8'h36.
- IDLE + start: round_key <= last_key, round_idx <= 10, rcon <= 8'h36, -> EMIT.
- EMIT: key_valid=1, busy=1. Outputs held stable while key_ready=0.
- Accepted beat with round_idx>0: compute previous key from current words w0..w3:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}; RotWord = {b1,b2,b3,b0}
  - round_key <= {p0,p1,p2,p3}, round_idx decrements
  - rcon update: 8'h1b -> 8'h80, otherwise rcon>>1 (sequence 36,1b,80,40,20,10,08,04,02,01)
- Accepted beat with round_idx=0: -> IDLE, key_valid<=0, done<=1 for one cycle; round_key holds round-0 key (equals original cipher key).
- start in EMIT: ignored. start in the cycle done is high: accepted (state is IDLE).
- rst_n low mid-sequence: immediate return to reset values; no done.
- last_key is sampled only on the start cycle; later changes have no effect.

## Timing
- start at edge T -> key_valid=1, round_idx=10 visible after edge T.
- With key_ready held high: one key per cycle, 11 beats, done pulses the cycle after the round-0 beat; start-to-done 12 cycles.
- Next key is combinational from the state register (XOR + one S-box word); registered on acceptance only. No output is combinational from inputs.
- key_ready low stalls indefinitely with no loss or change of state.

## Structure
- Shared package: AES constants (Nk, Nr, Nb), the forward rcon table, rcon start value 8'h36 and wrap constants (8'h1b -> 8'h80).
- Sub-module: existing SBytes with NWords=1 for SubWord; no other hierarchy.
- RotWord, rcon step and word XORs inline.

## Test plan
- FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> round 10 = last_key, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done at start+12.
- Random keys: drive forward key expansion, feed its round-10 key here -> all 11 keys match forward output in reverse order.
- Backpressure: random key_ready -> each key appears exactly once, held stable while stalled, same sequence as above.
- start pulses during EMIT -> ignored; sequence and done timing unchanged.
- rst_n asserted at round_idx=5 -> outputs to reset values asynchronously; fresh start then produces full correct sequence.
- Back-to-back: start in done cycle -> new sequence begins, key_valid high next cycle with round_idx=10.
